// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer and the control unit
// that issues requests to it.
package mem_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Encoding of the rw strobe, shared with the control unit
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Cycles allowed in any single handshake phase before the access is aborted
    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_sequencer_handshake_timer.sv
// Phase timer for the MOV/MOC handshake. Counts up from zero while enabled
// and flags the last permitted cycle of a phase. It saturates there, so a
// phase that somehow stays open can never wrap back to a fresh budget.
module handshake_timer
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Clear takes priority; counting stops at the last cycle of the budget
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // Decoded from the registered count only
    assign expired = (count == LAST);

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle memory access sequencer. Latches one read/write request from
// the control unit into MAR/MDR, runs the four-phase MOV/MOC handshake with
// the memory port and reports completion (optionally with error on timeout).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req; moc ignored
// REQ   | mov high, waiting for moc to rise (read data captured here)
// ACK   | mov low, waiting for moc to fall
// DONE  | one-cycle done pulse, error set if either phase timed out
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mdr_out,
    input  logic [DATA_W-1:0] mdr_in,
    output logic              mov,
    output logic              mem_rw,
    input  logic              moc
);

    seq_state_t        state;
    logic [DATA_W-1:0] mdr;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_expired;

    // The timer only runs while the FSM stays in a handshake phase; any
    // cycle that leaves (or is outside) a phase clears it, so every state
    // entry starts from zero.
    always_comb begin
        timer_enable = 1'b0;
        case (state)
            REQ:     timer_enable = !moc && !timer_expired;
            ACK:     timer_enable =  moc && !timer_expired;
            default: timer_enable = 1'b0;
        endcase
    end

    assign timer_clear = !timer_enable;

    handshake_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Sequencer FSM with registered handshake, status and data outputs.
    // A rising moc beats an expiring timer, so a late ack is never an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mov    <= 1'b0;
            mem_rw <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            mar    <= '0;
            mdr    <= '0;
            rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        mar    <= addr;
                        mdr    <= wdata;
                        mem_rw <= rw;
                        mov    <= 1'b1;
                        busy   <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (moc) begin
                        if (mem_rw == RW_READ) begin
                            mdr   <= mdr_in;
                            rdata <= mdr_in;
                        end
                        mov   <= 1'b0;
                        state <= ACK;
                    end else if (timer_expired) begin
                        mov   <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                        state <= DONE;
                    end
                end
                ACK: begin
                    if (!moc) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (timer_expired) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mdr_out = mdr;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer. Each accepted access is described by when the
// memory raises moc (k, offset from acceptance) and how long it holds it
// (j extra cycles); the expected timeline follows from those by arithmetic.
module tb_mem_sequencer;
    import mem_seq_pkg::*;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset, req, rw, moc;
    logic [31:0] addr, wdata, mdr_in;
    logic [31:0] rdata, mar, mdr_out;
    logic        busy, done, error, mov, mem_rw;

    always #5 clk = ~clk;

    mem_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .error(error), .rdata(rdata), .mar(mar),
        .mdr_out(mdr_out), .mdr_in(mdr_in), .mov(mov), .mem_rw(mem_rw), .moc(moc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model
    bit          active = 1'b0;
    int          t, k, j, rq_len, total;
    bit          acc_err, acc_rw;
    logic [31:0] m_mar = '0, m_mdr = '0, m_rdata = '0, rd_word = '0;
    logic        m_rw = 1'b0;

    // Expected outputs for the current cycle
    bit          exp_busy, exp_mov, exp_done, exp_error, exp_rw;
    logic [31:0] exp_mar, exp_mdr, exp_rdata;
    bit          chk_en = 1'b0;

    bit          forced = 1'b0;
    int          f_k, f_j;
    logic [31:0] f_word;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: publish expectations, drive inputs, advance model
    task automatic step(input bit rq, input bit r, input logic [31:0] a,
                        input logic [31:0] wd, input bit rst);
        exp_busy  = active;
        exp_mov   = active && (t <= rq_len);
        exp_done  = active && (t == total);
        exp_error = exp_done && acc_err;
        exp_rw    = m_rw;
        exp_mar   = m_mar;
        exp_mdr   = m_mdr;
        exp_rdata = m_rdata;

        reset = rst; req = rq; rw = r; addr = a; wdata = wd;
        if (active) begin
            moc    = (t >= k) && (t <= k + j);
            mdr_in = (t == k) ? rd_word : $urandom();
        end else begin
            moc    = 1'($urandom_range(0, 1));
            mdr_in = $urandom();
        end

        if (rst) begin
            active = 1'b0; m_mar = '0; m_mdr = '0; m_rdata = '0; m_rw = 1'b0;
        end else if (active) begin
            if (t == k && k <= T && acc_rw == RW_READ) begin
                m_mdr   = rd_word;
                m_rdata = rd_word;
            end
            t++;
            if (t > total) active = 1'b0;
        end else if (rq) begin
            active = 1'b1; t = 1; acc_rw = r;
            m_mar = a; m_mdr = wd; m_rw = r;
            if (forced) begin
                k = f_k; j = f_j; rd_word = f_word; forced = 1'b0;
            end else begin
                case ($urandom_range(0, 9))
                    0:       k = T + 1 + int'($urandom_range(0, 5));
                    1:       k = T;
                    default: k = int'($urandom_range(1, 5));
                endcase
                case ($urandom_range(0, 9))
                    0:       j = T - 1;
                    1:       j = T;
                    2:       j = T + 10;
                    default: j = int'($urandom_range(0, 3));
                endcase
                rd_word = $urandom();
            end
            rq_len = (k <= T) ? k : T;
            if (k > T) begin
                total   = T + 1;
                acc_err = 1'b1;
            end else begin
                total   = k + ((j + 1 <= T) ? j + 1 : T) + 1;
                acc_err = (j >= T);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one access with a fixed memory behaviour and observe the DUT
    task automatic access(input bit r, input logic [31:0] a, input logic [31:0] wd,
                          input int kk, input int jj, input logic [31:0] word, input bit poke,
                          output int mov_cnt, output int done_at, output bit err_seen);
        forced = 1'b1; f_k = kk; f_j = jj; f_word = word;
        mov_cnt = 0; done_at = -1; err_seen = 1'b0;
        step(1'b1, r, a, wd, 1'b0);
        for (int c = 1; c <= 4 * T; c++) begin
            if (mov) mov_cnt++;
            if (done) begin
                done_at  = c;
                err_seen = error;
            end
            step(poke && (c % 2 == 1), ~r, ~a, ~wd, 1'b0);
            if (done_at > 0) break;
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    32'(busy),   32'(exp_busy));
            chk("mov",     32'(mov),    32'(exp_mov));
            chk("done",    32'(done),   32'(exp_done));
            chk("error",   32'(error),  32'(exp_error));
            chk("mem_rw",  32'(mem_rw), 32'(exp_rw));
            chk("mar",     mar,         exp_mar);
            chk("mdr_out", mdr_out,     exp_mdr);
            chk("rdata",   rdata,       exp_rdata);
        end
    end

    initial begin
        int  mc, da;
        bit  es;
        reset = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; moc = 1'b0; mdr_in = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mar",  mar,       32'h0);
        chk("rst_rdata", rdata,    32'h0);

        // Zero-wait read
        access(RW_READ, 32'h10, 32'h0, 1, 0, 32'hDEADBEEF, 1'b0, mc, da, es);
        chk("rd_done_at", 32'(da), 32'd3);
        chk("rd_err",     32'(es), 32'd0);
        chk("rd_mov_cnt", 32'(mc), 32'd1);
        chk("rd_mar",     mar,     32'h10);
        chk("rd_rdata",   rdata,   32'hDEADBEEF);

        // Write with a slow memory, req poked while busy
        access(RW_WRITE, 32'h20, 32'h12345678, 6, 0, 32'h0, 1'b1, mc, da, es);
        chk("wr_mov_cnt", 32'(mc),     32'd6);
        chk("wr_done_at", 32'(da),     32'd8);
        chk("wr_err",     32'(es),     32'd0);
        chk("wr_mdr",     mdr_out,     32'h12345678);
        chk("wr_mem_rw",  32'(mem_rw), 32'd0);
        chk("wr_mar",     mar,         32'h20);
        chk("wr_rdata",   rdata,       32'hDEADBEEF);

        // Read that is never acknowledged
        access(RW_READ, 32'h30, 32'h0, 1000, 0, 32'h55AA55AA, 1'b1, mc, da, es);
        chk("to_mov_cnt", 32'(mc), 32'd15);
        chk("to_done_at", 32'(da), 32'd16);
        chk("to_err",     32'(es), 32'd1);
        chk("to_rdata",   rdata,   32'hDEADBEEF);

        // moc stuck high after the ack
        access(RW_READ, 32'h34, 32'h0, 2, 1000, 32'hCAFE0001, 1'b0, mc, da, es);
        chk("ackto_done_at", 32'(da), 32'd18);
        chk("ackto_err",     32'(es), 32'd1);
        chk("ackto_mov_cnt", 32'(mc), 32'd2);

        // Next request goes through normally
        access(RW_READ, 32'h38, 32'h0, 1, 0, 32'h0BADF00D, 1'b0, mc, da, es);
        chk("after_done_at", 32'(da), 32'd3);
        chk("after_err",     32'(es), 32'd0);
        chk("after_rdata",   rdata,   32'h0BADF00D);

        // Ack arriving on the last allowed cycle wins over the timeout
        access(RW_WRITE, 32'h3C, 32'hA5A5A5A5, T, 0, 32'h0, 1'b0, mc, da, es);
        chk("edge_mov_cnt", 32'(mc), 32'd15);
        chk("edge_done_at", 32'(da), 32'd17);
        chk("edge_err",     32'(es), 32'd0);

        // Reset in the middle of REQ
        forced = 1'b1; f_k = 1000; f_j = 0; f_word = 32'h0;
        step(1'b1, RW_READ, 32'h40, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("mrst_mov",  32'(mov),  32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_mar",  mar,       32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mrst_done2", 32'(done), 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                 $urandom_range(0, 799) == 0);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multi-cycle memory access sequencer that sits between the control unit and the memory port. It accepts a single read or write request, loads MAR/MDR, and drives the MOV/MOC four-phase handshake. It returns read data or an error pulse on timeout. The control unit stalls on `busy` while an access is in flight.

## Interface
- `ADDR_W`, 32: MAR width.
- `DATA_W`, 32: MDR width.
- `TIMEOUT`, 15: max cycles spent in any one handshake phase before abort; legal range ≥1.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  access strobe from control unit; sampled only in IDLE.
- `rw`  in  1  1 = read, 0 = write; sampled with `req`.
- `addr`  in  ADDR_W  access address; sampled with `req`.
- `wdata`  in  DATA_W  store data; sampled with `req`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  one-cycle pulse, only coincident with `done`, on timeout.
- `rdata`  out  DATA_W  last successfully read word.
- `mar`  out  ADDR_W  MAR contents to memory address bus.
- `mdr_out`  out  DATA_W  MDR contents to memory write bus.
- `mdr_in`  in  DATA_W  memory read bus.
- `mov`  out  1  memory operation valid.
- `mem_rw`  out  1  latched `rw`, valid whenever `mov`=1.
- `moc`  in  1  memory operation complete.

## Operation
- States: IDLE, REQ, ACK, DONE.
- IDLE: if `req`=1 at edge, then MAR←`addr`, MDR←`wdata`, mem_rw←`rw`, timer←0, →REQ. Otherwise hold.
- REQ: `mov`=1. If `moc`=1 at edge: on read, MDR←`mdr_in` and rdata←`mdr_in`; timer←0; →ACK. Else if timer=TIMEOUT−1: set error flag, →DONE. Else timer+1.
- ACK: `mov`=0. If `moc`=0 at edge: →DONE. Else if timer=TIMEOUT−1: set error flag, →DONE. Else timer+1.
- DONE: `done`=1, `error`=error flag. Clear flag, →IDLE.
- `req` outside IDLE is ignored. There is no queuing; the requester re-issues after `done`.
- Write: `rdata` unchanged. Timed-out read: `rdata` and MDR unchanged.
- Timer width is clog2(TIMEOUT+1). Timer is cleared on every state entry and never wraps.
- `moc` high in IDLE is ignored.

## Timing
- Reset values: state IDLE; `mov`, `mem_rw`, `busy`, `done`, `error` = 0; `mar`, `mdr_out`, `rdata`, timer = 0.
- Reset mid-access: next cycle is IDLE with `mov`=0. Memory sees an aborted handshake, and no `done` is issued.
- All outputs are registered or decoded from registered state only. There is no combinational path from `moc` to `mov`.
- Zero-wait memory, with `req` at edge n:
  - `mov`=1 in cycle n+1.
  - `moc` seen at end of n+1 → ACK in n+2.
  - `moc` low at end of n+2 → `done` in n+3.
  - IDLE in n+4; earliest next `req` is sampled at end of n+4.
  - Minimum access is 4 cycles.
- `mov` high for exactly the REQ duration: 1..TIMEOUT cycles.
- Timeout in REQ: `mov` high for TIMEOUT cycles, then DONE with `error`=1 next cycle.
- `moc` rising in the same cycle the timer hits TIMEOUT−1: `moc` wins; no error.

## Structure
- Shared package `mem_seq_pkg`:
  - state enum (IDLE, REQ, ACK, DONE);
  - constants RW_READ=1, RW_WRITE=0;
  - default TIMEOUT.
- The control unit imports RW_* from the same package.
- One sub-module: `handshake_timer`. It is parameterised by TIMEOUT, with inputs clear/enable and output `expired`.
- MAR/MDR/rdata registers and the FSM live in `mem_sequencer`.

## Test plan
- Read, `moc` asserted 1 cycle after `mov` and dropped 1 cycle after `mov` falls; `addr`=0x10, `mdr_in`=0xDEADBEEF → `mar`=0x10; `rdata`=0xDEADBEEF; `done` at n+3; `error`=0.
- Write `addr`=0x20, `wdata`=0x12345678, memory waits 5 cycles → `mdr_out`=0x12345678; `mem_rw`=0; `mov` high 6 cycles; `rdata` unchanged; `done`=1, `error`=0.
- Read, `moc` never asserted, TIMEOUT=15 → `mov` high exactly 15 cycles; `done`=`error`=1 in the same cycle; `rdata` unchanged.
- `moc` stuck high after ack → ACK times out after 15 cycles; `done`=`error`=1; the next `req` is accepted normally.
- `req` pulsed during REQ/ACK/DONE → ignored; `mar` unchanged; exactly one `done` per accepted request.
- `reset` asserted mid-REQ → next cycle `mov`=0, `busy`=0, all outputs at reset values; no `done` pulse.
